// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and access-size helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic is_byte(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_BU);
    endfunction

    // Codes 011/110/111 fall through to word access.
    function automatic logic is_half(input logic [2:0] size);
        return (size == SZ_H) || (size == SZ_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        if (is_byte(size)) return 1'b0;
        if (is_half(size)) return lo[0];
        return lo != 2'b00;
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] size, input logic [1:0] lo);
        if (is_byte(size)) return lo;
        if (is_half(size)) return {lo[1], 1'b0};
        return 2'b00;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select, sign/zero extension and byte-lane mask for one word access
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [2:0]  size,
    output logic [31:0] data,
    output logic [3:0]  lane_mask
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = word[{lo, 3'b000} +: 8];
        half_v    = lo[1] ? word[31:16] : word[15:0];
        data      = word;
        lane_mask = 4'b1111;
        if (is_byte(size)) begin
            data      = size[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            lane_mask = 4'b0001 << lo;
        end else if (is_half(size)) begin
            data      = size[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            lane_mask = lo[1] ? 4'b1100 : 4'b0011;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable byte-addressed data memory; DMEM_MISALIGN_TRAP_EN enables misalignment errors
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int LATENCY        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 1 << (MEM_ADDR_WIDTH - 2);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t               state;
    logic [CW-1:0]             cnt;
    logic                      lat_we;
    logic [2:0]                lat_size;
    logic [MEM_ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wdata;

    logic [DATA_WIDTH-1:0]     mem [0:DEPTH-1];

    logic                      unused_addr_bits;
    logic [1:0]                eff_lo;
    logic                      err;
    logic                      commit;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic [3:0]                lane_mask;
    logic [DATA_WIDTH-1:0]     wr_lanes;

    assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign eff_lo = lat_addr[1:0];
    assign err    = is_misaligned(lat_size, lat_addr[1:0]);
`else
    assign eff_lo = align_lo(lat_size, lat_addr[1:0]);
    assign err    = 1'b0;
`endif

    // Storage is touched only on the edge that moves WAIT into RESP.
    assign commit  = (state == WAIT) && (cnt == '0);
    assign rd_word = mem[lat_addr[MEM_ADDR_WIDTH-1:2]];

    load_align u_align (
        .word      (rd_word),
        .lo        (eff_lo),
        .size      (lat_size),
        .data      (ld_data),
        .lane_mask (lane_mask)
    );

    always_comb begin
        wr_lanes = lat_wdata;
        if (is_byte(lat_size))      wr_lanes = {4{lat_wdata[7:0]}};
        else if (is_half(lat_size)) wr_lanes = {2{lat_wdata[15:0]}};
    end

    always_ff @(posedge clk) begin
        if (commit && lat_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[lat_addr[MEM_ADDR_WIDTH-1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // cnt holds the WAIT edges still to go, so resp_valid rises LATENCY edges after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr[MEM_ADDR_WIDTH-1:0];
                        lat_wdata <= req_wdata;
                        cnt       <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (lat_we || err) ? '0 : ld_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed plus randomized check of dmem_responder against a byte-array model
module tb_dmem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mm [int];

    dmem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(17), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    task automatic model_op(input logic we, input logic [2:0] s, input logic [31:0] a_in,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int n;
        int a;
        logic [31:0] v;
        n   = nbytes(s);
        a   = int'(a_in & 32'h1FFFF);
        rd  = 32'h0;
        err = 1'b0;
        if (a % n != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        if (we) begin
            for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mm[a + i]) << (8 * i));
            if ((s == 3'd0 || s == 3'd1) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = s;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
    endtask

    task automatic finish_resp(input int stall, input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!resp_valid && k < 20);
        chk({tag, "_latency"}, 32'(k), 32'(LAT));
        if (!resp_valid) return;
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'h1);
            chk({tag, "_hold_rdata"}, resp_rdata, exp_rd);
            chk({tag, "_hold_ready"}, {31'b0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, {31'b0, resp_valid}, 32'h0);
        chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
    endtask

    task automatic op(input logic we, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input int stall, input string tag);
        logic [31:0] rd;
        logic        e;
        model_op(we, s, a, wd, rd, e);
        issue(we, s, a, wd);
        finish_resp(stall, rd, e, tag);
    endtask

    initial begin
        logic        we;
        logic [2:0]  s;
        logic [31:0] a;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

        op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, "sw_100");
        op(1'b0, 3'd2, 32'h100, 32'h0, 2, "lw_100");
        op(1'b0, 3'd0, 32'h101, 32'h0, 0, "lb_101");
        op(1'b0, 3'd4, 32'h103, 32'h0, 1, "lbu_103");
        op(1'b0, 3'd1, 32'h102, 32'h0, 0, "lh_102");
        op(1'b1, 3'd0, 32'h101, 32'h12, 0, "sb_101");
        op(1'b0, 3'd2, 32'h100, 32'h0, 0, "lw_after_sb");
        op(1'b1, 3'd1, 32'h102, 32'h0000CAFE, 0, "sh_102");
        op(1'b0, 3'd2, 32'h100, 32'h0, 0, "lw_after_sh");

        op(1'b0, 3'd2, 32'h102, 32'h0, 0, "lw_misal_102");
        op(1'b1, 3'd2, 32'h102, 32'h87654321, 0, "sw_misal_102");
        op(1'b0, 3'd2, 32'h100, 32'h0, 0, "lw_after_misal_sw");

        op(1'b1, 3'd2, 32'h0002_0004, 32'h11223344, 0, "sw_alias");
        op(1'b0, 3'd2, 32'h4, 32'h0, 0, "lw_alias");

        op(1'b1, 3'd2, 32'h200, 32'hA5A5A5A5, 0, "sw_200_prior");
        issue(1'b1, 3'd2, 32'h200, 32'h55);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midwait_rst_valid", {31'b0, resp_valid}, 32'h0);
        chk("midwait_rst_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", {31'b0, req_ready}, 32'h1);
        chk("after_rst_valid", {31'b0, resp_valid}, 32'h0);
        op(1'b0, 3'd2, 32'h200, 32'h0, 0, "lw_200_prior");

        for (int i = 0; i < 16; i++) op(1'b1, 3'd2, 32'h300 + 32'(4 * i), $urandom, 0, "rnd_init");
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            s  = 3'($urandom_range(0, 7));
            a  = 32'h300 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 17);
            op(we, s, a, $urandom, $urandom_range(0, 2), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
